// File: rtl/amp_mod_pkg.sv
// amp_mod_pkg: shared mode encoding, latency constant and saturation helper for amp_mod_stream
package amp_mod_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_RING   = 2'b01,
    MODE_AM     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  localparam int AMP_MOD_LATENCY = 3;
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/amp_mod_lane.sv
// amp_mod_lane: one lane's gain, multiply, shift, clamp and saturation flag (stages 2 and 3)
module amp_mod_lane
  import amp_mod_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  mode_e               mode_i,
  input  logic [W-1:0]        depth_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] m_i,
  output logic signed [W-1:0] y_o,
  output logic                sat_o
);
  localparam logic signed [W+1:0] UNITY = (W + 2)'(1) <<< (W - 1);
  logic signed [2*W:0]   am_p;
  logic signed [W+1:0]   gain_d, gain_q;
  logic signed [W-1:0]   c_q;
  logic signed [2*W+1:0] p;
  logic signed [W+2:0]   r;
  logic signed [31:0]    r_ext, r_sat;
  // gain select from the stage-1 beat, then floor-shifted product and clamp of the stage-2 beat
  always_comb begin
    am_p   = $signed({1'b0, depth_i}) * m_i;
    gain_d = mode_i == MODE_RING ? (W + 2)'(m_i)
           : mode_i == MODE_AM   ? UNITY + (W + 2)'(am_p >>> W)
           : UNITY;
    p      = c_q * gain_q;
    r      = (W + 3)'(p >>> (W - 1));
    r_ext  = 32'(r);
    r_sat  = sat_to_width(r_ext, W);
  end
  // stage 2 holds carrier and gain, stage 3 holds the clamped result and its flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gain_q <= '0;
      c_q    <= '0;
      y_o    <= '0;
      sat_o  <= 1'b0;
    end else if (en_i) begin
      gain_q <= gain_d;
      c_q    <= c_i;
      y_o    <= r_sat[W-1:0];
      sat_o  <= r_sat != r_ext;
    end
  end
endmodule

// File: rtl/amp_mod_stream.sv
// amp_mod_stream: multi-lane pipelined ring/AM modulator with valid/ready stream and saturation counter
module amp_mod_stream
  import amp_mod_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [1:0]                   mode_i,
  input  logic [DATA_WIDTH-1:0]        depth_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] carrier_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] modulator_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] signal_o,
  output logic [NUM_CH-1:0]            sat_o,
  input  logic                         sat_clr_i,
  output logic [CNT_WIDTH-1:0]         sat_count_o
);
  localparam int W = DATA_WIDTH;
  logic                adv;
  logic                v1_q, v2_q, vo_q;
  mode_e               mode_q;
  logic [W-1:0]        depth_q;
  logic [NUM_CH*W-1:0] c_q, m_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  assign adv         = !vo_q || ready_i;
  assign ready_o     = adv;
  assign valid_o     = vo_q;
  assign sat_count_o = cnt_q;
  // valid pipeline and stage-1 capture, all frozen together while the output is stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      vo_q    <= 1'b0;
      mode_q  <= MODE_BYPASS;
      depth_q <= '0;
      c_q     <= '0;
      m_q     <= '0;
    end else if (adv) begin
      v1_q    <= valid_i;
      v2_q    <= v1_q;
      vo_q    <= v2_q;
      mode_q  <= mode_e'(mode_i);
      depth_q <= depth_i;
      c_q     <= carrier_i;
      m_q     <= modulator_i;
    end
  end
  // clear has priority; count saturated handshakes and stick at all-ones
  always_comb begin
    cnt_d = sat_clr_i ? '0
          : (valid_o && ready_i && |sat_o && !(&cnt_q)) ? cnt_q + 1'b1
          : cnt_q;
  end
  // saturation event counter register
  always_ff @(posedge clk_i) begin
    cnt_q <= rst_i ? '0 : cnt_d;
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    amp_mod_lane #(.W(W)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (adv),
      .mode_i (mode_q),
      .depth_i(depth_q),
      .c_i    (c_q[k*W +: W]),
      .m_i    (m_q[k*W +: W]),
      .y_o    (signal_o[k*W +: W]),
      .sat_o  (sat_o[k])
    );
  end
endmodule

// File: tb/tb_amp_mod_stream.sv
// tb_amp_mod_stream: scoreboard bench for amp_mod_stream with directed, hand-computed vectors
module tb_amp_mod_stream;
  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_i, sat_clr_i;
  logic [1:0]  mode_i;
  logic [15:0] depth_i;
  logic [31:0] carrier_i, modulator_i;
  logic        ready_o, valid_o;
  logic [31:0] signal_o;
  logic [1:0]  sat_o;
  logic [15:0] sat_count_o;
  logic        ready2, valid2;
  logic [31:0] sig2;
  logic [1:0]  sat2;
  logic [1:0]  cnt2;
  typedef struct {
    logic [31:0] sig;
    logic [1:0]  sat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  amp_mod_stream dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
    .depth_i(depth_i), .carrier_i(carrier_i), .modulator_i(modulator_i), .valid_o(valid_o),
    .ready_i(ready_i), .signal_o(signal_o), .sat_o(sat_o), .sat_clr_i(sat_clr_i),
    .sat_count_o(sat_count_o)
  );

  amp_mod_stream #(.CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready2), .mode_i(mode_i),
    .depth_i(depth_i), .carrier_i(carrier_i), .modulator_i(modulator_i), .valid_o(valid2),
    .ready_i(ready_i), .signal_o(sig2), .sat_o(sat2), .sat_clr_i(sat_clr_i),
    .sat_count_o(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", signal_o);
      end else begin
        e = sb.pop_front();
        chk("sb_signal", signal_o, e.sig);
        chk("sb_sat", {30'd0, sat_o}, {30'd0, e.sat});
      end
    end
  end

  task automatic send(input logic [31:0] c, input logic [31:0] m, input logic [1:0] md,
                      input logic [15:0] d, input logic [31:0] es, input logic [1:0] esat,
                      input bit push);
    int n = 0;
    bit acc = 0;
    carrier_i   = c;
    modulator_i = m;
    mode_i      = md;
    depth_i     = d;
    valid_i     = 1'b1;
    if (push) sb.push_back('{es, esat});
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic latency_check(input string name);
    int lat = 1;
    @(negedge clk);
    while (!valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk(name, lat, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] snap;
    int n;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sat_clr_i = 1'b0;
    mode_i = 2'b00; depth_i = '0; carrier_i = '0; modulator_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_signal", signal_o, 0);
    chk("rst_sat", {30'd0, sat_o}, 0);
    chk("rst_count", {16'd0, sat_count_o}, 0);
    rst_i = 1'b0;
    chk("rst_ready", {31'd0, ready_o}, 1);

    send(32'h4000_4000, 32'h4000_4000, 2'b01, 16'h0, 32'h2000_2000, 2'b00, 1);
    latency_check("latency_ring");
    drain();
    chk("count_t1", {16'd0, sat_count_o}, 0);

    send(32'h4000_8000, 32'hC000_8000, 2'b01, 16'h0, 32'hE000_7FFF, 2'b01, 1);
    drain();
    chk("count_t2", {16'd0, sat_count_o}, 1);

    send(32'h4000_4000, 32'h7FFF_7FFF, 2'b10, 16'h8000, 32'h5FFF_5FFF, 2'b00, 1);
    send(32'h4000_4000, 32'h7FFF_7FFF, 2'b10, 16'h0000, 32'h4000_4000, 2'b00, 1);
    send(32'h8000_1234, 32'h7FFF_7FFF, 2'b11, 16'h8000, 32'h8000_1234, 2'b00, 1);
    send(32'h8000_4000, 32'h8000_8000, 2'b10, 16'h8000, 32'hC000_2000, 2'b00, 1);
    send(32'h4000_4000, 32'hFFFF_FFFF, 2'b10, 16'h0001, 32'h3FFF_3FFF, 2'b00, 1);
    send(32'h7FFF_0001, 32'h7FFF_FFFF, 2'b01, 16'h0, 32'h7FFE_FFFF, 2'b00, 1);
    send(32'h8000_7FFF, 32'h8000_8000, 2'b00, 16'h0, 32'h8000_7FFF, 2'b00, 1);
    drain();
    chk("count_t3", {16'd0, sat_count_o}, 1);

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [15:0] a, b, ea, eb;
          a  = 16'(4096 * (i + 1));
          b  = 16'(-4096 * (i + 1));
          ea = 16'(2048 * (i + 1));
          eb = 16'(-2048 * (i + 1));
          send({b, a}, 32'h4000_4000, 2'b01, 16'h0, {eb, ea}, 2'b00, 1);
        end
      end
      begin
        n = 0;
        while (!valid_o && n < 20) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        snap = signal_o;
        chk("stall_value", snap, 32'hF000_1000);
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, valid_o}, 1);
          chk("stall_hold", signal_o, snap);
          chk("stall_ready", {31'd0, ready_o}, 0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    sat_clr_i = 1'b1;
    @(posedge clk);
    #1;
    sat_clr_i = 1'b0;
    chk("count_clr", {16'd0, sat_count_o}, 0);
    repeat (3) send(32'h8000_8000, 32'h8000_8000, 2'b01, 16'h0, 32'h7FFF_7FFF, 2'b11, 1);
    drain();
    chk("count_three", {16'd0, sat_count_o}, 3);
    send(32'h8000_8000, 32'h8000_8000, 2'b01, 16'h0, 32'h7FFF_7FFF, 2'b11, 1);
    n = 0;
    while (!valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("clr_wait_valid", {31'd0, valid_o}, 1);
    sat_clr_i = 1'b1;
    @(posedge clk);
    #1;
    sat_clr_i = 1'b0;
    chk("count_clr_wins", {16'd0, sat_count_o}, 0);
    chk("count2_clr_wins", {30'd0, cnt2}, 0);
    repeat (5) send(32'h8000_8000, 32'h8000_8000, 2'b01, 16'h0, 32'h7FFF_7FFF, 2'b11, 1);
    drain();
    chk("count_five", {16'd0, sat_count_o}, 5);
    chk("count2_sticky", {30'd0, cnt2}, 3);

    send(32'h4000_4000, 32'h4000_4000, 2'b01, 16'h0, 32'h0, 2'b00, 0);
    send(32'h4000_4000, 32'h4000_4000, 2'b01, 16'h0, 32'h0, 2'b00, 0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 0);
    chk("midrst_signal", signal_o, 0);
    chk("midrst_sat", {30'd0, sat_o}, 0);
    chk("midrst_count", {16'd0, sat_count_o}, 0);
    chk("midrst_count2", {30'd0, cnt2}, 0);
    rst_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_discard", {31'd0, valid_o}, 0);
    end
    @(posedge clk);
    #1;
    send(32'hC000_4000, 32'h4000_4000, 2'b10, 16'h4000, 32'hB800_4800, 2'b00, 1);
    latency_check("latency_after_rst");
    drain();
    chk("count_final", {16'd0, sat_count_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
